// File: rtl/audio_pdm_rx_pkg.sv
// Shared constants and helpers for the interleaved PDM audio receiver.
package audio_pdm_rx_pkg;

    localparam int DEFAULT_CHANNELS = 2;
    localparam int DEFAULT_DEC_LOG2 = 6;

    // A single-channel build still needs a 1-bit slot counter to stay legal.
    function automatic int slot_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/audio_pdm_rx_chan_acc.sv
// Single-channel popcount accumulator with its own slice of the output register.
module pdm_chan_acc #(
    parameter int OUT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    input  logic             load_out,
    output logic [OUT_W-1:0] pcm
);

    logic [OUT_W-1:0] acc;

    // The load folds in this cycle's bit so the last channel's final sample is counted.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            pcm <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (load_out) begin
            pcm <= acc + OUT_W'(inc);
            acc <= '0;
        end else if (inc) begin
            acc <= acc + OUT_W'(1);
        end
    end

endmodule

// File: rtl/audio_pdm_rx.sv
// De-interleaves a 1-bit PDM stream into CHANNELS channels and decimates each by popcount.
module audio_pdm_rx
    import audio_pdm_rx_pkg::*;
#(
    parameter int CHANNELS = DEFAULT_CHANNELS,
    parameter int DEC_LOG2 = DEFAULT_DEC_LOG2,
    parameter int OUT_W    = DEC_LOG2 + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    din,
    input  logic                    sync,
    output logic [CHANNELS*OUT_W-1:0] pcm_out,
    output logic                    pcm_valid,
    input  logic                    pcm_ready,
    output logic                    overrun,
    input  logic                    overrun_clr
);

    localparam int CH_W = slot_width(CHANNELS);

    logic [CH_W-1:0]     ch;
    logic [DEC_LOG2-1:0] wcnt;
    logic                step;
    logic                last_slot;
    logic                complete;

    assign step      = en & ~sync;
    assign last_slot = (ch == CH_W'(CHANNELS - 1));
    assign complete  = step & last_slot & (&wcnt);

    always_ff @(posedge clk) begin
        if (rst || sync) begin
            ch   <= '0;
            wcnt <= '0;
        end else if (step) begin
            if (last_slot) begin
                ch   <= '0;
                wcnt <= wcnt + DEC_LOG2'(1);
            end else begin
                ch <= ch + CH_W'(1);
            end
        end
    end

    genvar i;
    generate
        for (i = 0; i < CHANNELS; i++) begin : g_chan
            logic inc;
            assign inc = step & din & (ch == CH_W'(i));

            pdm_chan_acc #(
                .OUT_W(OUT_W)
            ) u_acc (
                .clk     (clk),
                .rst     (rst),
                .inc     (inc),
                .clr     (sync),
                .load_out(complete),
                .pcm     (pcm_out[i*OUT_W +: OUT_W])
            );
        end
    endgenerate

    // A completion always leaves valid high; overrun only when the old set was never taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            pcm_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (complete) begin
                pcm_valid <= 1'b1;
            end else if (pcm_valid && pcm_ready) begin
                pcm_valid <= 1'b0;
            end

            if (complete && pcm_valid && !pcm_ready) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_audio_pdm_rx.sv
// Directed self-checking bench for audio_pdm_rx with CHANNELS=2, DEC_LOG2=2.
module tb_audio_pdm_rx;

    localparam int CHANNELS = 2;
    localparam int DEC_LOG2 = 2;
    localparam int OUT_W    = DEC_LOG2 + 1;

    logic                      clk = 1'b0;
    logic                      rst;
    logic                      en;
    logic                      din;
    logic                      sync;
    logic [CHANNELS*OUT_W-1:0] pcm_out;
    logic                      pcm_valid;
    logic                      pcm_ready;
    logic                      overrun;
    logic                      overrun_clr;

    int assertCount = 0;
    int failCount   = 0;
    int earlyValid;

    audio_pdm_rx #(
        .CHANNELS(CHANNELS),
        .DEC_LOG2(DEC_LOG2),
        .OUT_W   (OUT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .din        (din),
        .sync       (sync),
        .pcm_out    (pcm_out),
        .pcm_valid  (pcm_valid),
        .pcm_ready  (pcm_ready),
        .overrun    (overrun),
        .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs on the falling edge; return 1ns after the rising edge.
    task automatic applyStimulus(input logic e, input logic d, input logic s,
                                 input logic rdy, input logic clr);
        @(negedge clk);
        en          = e;
        din         = d;
        sync        = s;
        pcm_ready   = rdy;
        overrun_clr = clr;
        @(posedge clk);
        #1;
    endtask

    // Feeds 8 enabled bits (bits[0] first); counts valid seen after any of the first 7.
    task automatic feedBits(input logic [7:0] bits, input logic rdy, input logic lastRdy,
                            output int early);
        early = 0;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, bits[k], 1'b0, (k == 7) ? lastRdy : rdy, 1'b0);
            if (k < 7 && pcm_valid) early++;
        end
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0; din = 1'b0; sync = 1'b0; pcm_ready = 1'b0; overrun_clr = 1'b0;
        repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        checkOutput("reset_pcm_out", 32'(pcm_out), 32'h0);
        checkOutput("reset_valid", 32'(pcm_valid), 32'h0);
        checkOutput("reset_overrun", 32'(overrun), 32'h0);

        $display("[TB] basic window");
        feedBits(8'b0101_0101, 1'b1, 1'b1, earlyValid);
        checkOutput("basic_no_early_valid", 32'(earlyValid), 32'd0);
        checkOutput("basic_valid", 32'(pcm_valid), 32'h1);
        checkOutput("basic_pcm_out", 32'(pcm_out), 32'(6'b000_100));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("basic_valid_pulse_ends", 32'(pcm_valid), 32'h0);

        $display("[TB] gapped enable");
        earlyValid = 0;
        for (int k = 0; k < 16; k++) begin
            if (k[0] == 1'b0) applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            else              applyStimulus(1'b1, ~k[1], 1'b0, 1'b1, 1'b0);
            if (k < 15 && pcm_valid) earlyValid++;
        end
        checkOutput("gapped_no_early_valid", 32'(earlyValid), 32'd0);
        checkOutput("gapped_valid", 32'(pcm_valid), 32'h1);
        checkOutput("gapped_pcm_out", 32'(pcm_out), 32'(6'b000_100));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("[TB] mid-window sync");
        repeat (3) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        feedBits(8'hFF, 1'b1, 1'b1, earlyValid);
        checkOutput("sync_no_early_valid", 32'(earlyValid), 32'd0);
        checkOutput("sync_valid", 32'(pcm_valid), 32'h1);
        checkOutput("sync_pcm_out", 32'(pcm_out), 32'(6'b100_100));
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("[TB] backpressure and overrun");
        feedBits(8'b0101_0101, 1'b0, 1'b0, earlyValid);
        checkOutput("bp_first_valid", 32'(pcm_valid), 32'h1);
        checkOutput("bp_first_no_overrun", 32'(overrun), 32'h0);
        feedBits(8'b1010_1010, 1'b0, 1'b0, earlyValid);
        checkOutput("bp_second_valid", 32'(pcm_valid), 32'h1);
        checkOutput("bp_second_pcm_out", 32'(pcm_out), 32'(6'b100_000));
        checkOutput("bp_overrun_set", 32'(overrun), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("bp_transfer_drops_valid", 32'(pcm_valid), 32'h0);
        checkOutput("bp_overrun_sticky", 32'(overrun), 32'h1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("bp_overrun_cleared", 32'(overrun), 32'h0);

        $display("[TB] simultaneous transfer and completion");
        feedBits(8'hFF, 1'b0, 1'b0, earlyValid);
        checkOutput("sim_first_pcm_out", 32'(pcm_out), 32'(6'b100_100));
        feedBits(8'b1010_1010, 1'b0, 1'b1, earlyValid);
        checkOutput("sim_valid_held", 32'(pcm_valid), 32'h1);
        checkOutput("sim_pcm_out_new", 32'(pcm_out), 32'(6'b100_000));
        checkOutput("sim_no_overrun", 32'(overrun), 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("sim_valid_drops", 32'(pcm_valid), 32'h0);

        $display("[TB] reset mid-window");
        repeat (5) applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        rst = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        checkOutput("rst_mid_pcm_out", 32'(pcm_out), 32'h0);
        checkOutput("rst_mid_valid", 32'(pcm_valid), 32'h0);
        checkOutput("rst_mid_overrun", 32'(overrun), 32'h0);
        feedBits(8'b0111_0111, 1'b1, 1'b1, earlyValid);
        checkOutput("rst_mid_no_early_valid", 32'(earlyValid), 32'd0);
        checkOutput("rst_mid_valid_after", 32'(pcm_valid), 32'h1);
        checkOutput("rst_mid_pcm_out_after", 32'(pcm_out), 32'(6'b010_100));

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
